axi_mem_arbiter: RTL and testbench



---
 rtl/axi_mem_arb_pkg.sv | 200 ++++++++++++++++++++
 rtl/axi_mem_arb_rr_lock.sv | 58 +++++
 rtl/axi_mem_arbiter.sv | 147 ++++++++++++++
 tb/tb_axi_mem_arbiter.sv | 384 ++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/axi_mem_arb_pkg.sv
// axi_mem_arb_pkg
// Shared types and sizing for the two-master AXI4 memory arbiter.
//   - Design parameters (address/data/ID/user widths, W order FIFO depth).
//   - src_e: source tag prepended to every outgoing AXI ID (core=0, acc=1).
//   - slv_* channel/request/response structs (ID width AXI_ID_WIDTH) and
//     mst_* structs (ID width MST_ID_WIDTH). Their layout is the usual
//     AXI_TYPEDEF_ALL layout.
//   - tag_ar/tag_aw: widen a slave-side address channel with its source tag.
package axi_mem_arb_pkg;

    localparam int unsigned AXI_ADDR_WIDTH   = 64;
    localparam int unsigned AXI_DATA_WIDTH   = 128;
    localparam int unsigned AXI_ID_WIDTH     = 4;
    localparam int unsigned AXI_USER_WIDTH   = 1;
    localparam int unsigned W_FIFO_DEPTH     = 4;

    localparam int unsigned MST_ID_WIDTH     = AXI_ID_WIDTH + 1;
    localparam int unsigned W_FIFO_PTR_WIDTH = $clog2(W_FIFO_DEPTH);

    typedef enum logic {
        SRC_CORE = 1'b0,
        SRC_ACC  = 1'b1
    } src_e;

    typedef logic [AXI_ADDR_WIDTH-1:0]   addr_t;
    typedef logic [AXI_DATA_WIDTH-1:0]   data_t;
    typedef logic [AXI_DATA_WIDTH/8-1:0] strb_t;
    typedef logic [AXI_USER_WIDTH-1:0]   user_t;
    typedef logic [AXI_ID_WIDTH-1:0]     slv_id_t;
    typedef logic [MST_ID_WIDTH-1:0]     mst_id_t;

    typedef struct packed {
        slv_id_t    id;
        addr_t      addr;
        logic [7:0] len;
        logic [2:0] size;
        logic [1:0] burst;
        logic       lock;
        logic [3:0] cache;
        logic [2:0] prot;
        logic [3:0] qos;
        logic [3:0] region;
        logic [5:0] atop;
        user_t      user;
    } slv_aw_chan_t;

    typedef struct packed {
        mst_id_t    id;
        addr_t      addr;
        logic [7:0] len;
        logic [2:0] size;
        logic [1:0] burst;
        logic       lock;
        logic [3:0] cache;
        logic [2:0] prot;
        logic [3:0] qos;
        logic [3:0] region;
        logic [5:0] atop;
        user_t      user;
    } mst_aw_chan_t;

    typedef struct packed {
        data_t data;
        strb_t strb;
        logic  last;
        user_t user;
    } w_chan_t;

    typedef struct packed {
        slv_id_t    id;
        logic [1:0] resp;
        user_t      user;
    } slv_b_chan_t;

    typedef struct packed {
        mst_id_t    id;
        logic [1:0] resp;
        user_t      user;
    } mst_b_chan_t;

    typedef struct packed {
        slv_id_t    id;
        addr_t      addr;
        logic [7:0] len;
        logic [2:0] size;
        logic [1:0] burst;
        logic       lock;
        logic [3:0] cache;
        logic [2:0] prot;
        logic [3:0] qos;
        logic [3:0] region;
        user_t      user;
    } slv_ar_chan_t;

    typedef struct packed {
        mst_id_t    id;
        addr_t      addr;
        logic [7:0] len;
        logic [2:0] size;
        logic [1:0] burst;
        logic       lock;
        logic [3:0] cache;
        logic [2:0] prot;
        logic [3:0] qos;
        logic [3:0] region;
        user_t      user;
    } mst_ar_chan_t;

    typedef struct packed {
        slv_id_t    id;
        data_t      data;
        logic [1:0] resp;
        logic       last;
        user_t      user;
    } slv_r_chan_t;

    typedef struct packed {
        mst_id_t    id;
        data_t      data;
        logic [1:0] resp;
        logic       last;
        user_t      user;
    } mst_r_chan_t;

    typedef struct packed {
        slv_aw_chan_t aw;
        logic         aw_valid;
        w_chan_t      w;
        logic         w_valid;
        logic         b_ready;
        slv_ar_chan_t ar;
        logic         ar_valid;
        logic         r_ready;
    } slv_req_t;

    typedef struct packed {
        logic        aw_ready;
        logic        ar_ready;
        logic        w_ready;
        logic        b_valid;
        slv_b_chan_t b;
        logic        r_valid;
        slv_r_chan_t r;
    } slv_resp_t;

    typedef struct packed {
        mst_aw_chan_t aw;
        logic         aw_valid;
        w_chan_t      w;
        logic         w_valid;
        logic         b_ready;
        mst_ar_chan_t ar;
        logic         ar_valid;
        logic         r_ready;
    } mst_req_t;

    typedef struct packed {
        logic        aw_ready;
        logic        ar_ready;
        logic        w_ready;
        logic        b_valid;
        mst_b_chan_t b;
        logic        r_valid;
        mst_r_chan_t r;
    } mst_resp_t;

    function automatic mst_aw_chan_t tag_aw(input src_e src, input slv_aw_chan_t aw);
        mst_aw_chan_t t;
        t.id     = {src, aw.id};
        t.addr   = aw.addr;
        t.len    = aw.len;
        t.size   = aw.size;
        t.burst  = aw.burst;
        t.lock   = aw.lock;
        t.cache  = aw.cache;
        t.prot   = aw.prot;
        t.qos    = aw.qos;
        t.region = aw.region;
        t.atop   = aw.atop;
        t.user   = aw.user;
        return t;
    endfunction

    function automatic mst_ar_chan_t tag_ar(input src_e src, input slv_ar_chan_t ar);
        mst_ar_chan_t t;
        t.id     = {src, ar.id};
        t.addr   = ar.addr;
        t.len    = ar.len;
        t.size   = ar.size;
        t.burst  = ar.burst;
        t.lock   = ar.lock;
        t.cache  = ar.cache;
        t.prot   = ar.prot;
        t.qos    = ar.qos;
        t.region = ar.region;
        t.user   = ar.user;
        return t;
    endfunction

endpackage

// File: rtl/axi_mem_arb_rr_lock.sv
// axi_mem_arb_rr_lock
// Two-request round-robin arbiter with a grant lock, for one AXI address
// channel. Once the selected request is presented downstream without being
// accepted, the grant is frozen until the handshake so the downstream
// payload stays stable.
// Ports:
//   clk, rst   clock, synchronous active-high reset
//   req[1:0]   request valids, bit index = src_e encoding
//   gnt_en     channel may transfer this cycle (e.g. W order FIFO not full)
//   valid_out  downstream valid as driven by the parent
//   ready_in   downstream ready
//   gnt_src    granted source (combinational)
module axi_mem_arb_rr_lock
    import axi_mem_arb_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] req,
    input  logic       gnt_en,
    input  logic       valid_out,
    input  logic       ready_in,
    output src_e       gnt_src
);

    src_e ptr_q;
    src_e lock_src_q;
    logic lock_q;

    // With no request the pointer value is output; it is a don't-care
    // because the parent's valid is then low.
    always_comb begin
        gnt_src = ptr_q;
        if (lock_q) begin
            gnt_src = lock_src_q;
        end else if (req == 2'b01) begin
            gnt_src = SRC_CORE;
        end else if (req == 2'b10) begin
            gnt_src = SRC_ACC;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ptr_q      <= SRC_CORE;
            lock_q     <= 1'b0;
            lock_src_q <= SRC_CORE;
        end else if (gnt_en && valid_out) begin
            if (ready_in) begin
                lock_q <= 1'b0;
                ptr_q  <= (gnt_src == SRC_CORE) ? SRC_ACC : SRC_CORE;
            end else begin
                lock_q     <= 1'b1;
                lock_src_q <= gnt_src;
            end
        end
    end

endmodule

// File: rtl/axi_mem_arbiter.sv
// axi_mem_arbiter
// Shares one AXI4 memory master port between the CVA6 core and the matrix
// accelerator. AR and AW are arbitrated independently (round-robin with
// lock), the outgoing ID carries the source in its MSB, R/B are routed back
// by that MSB, and W beats follow AW grant order through a small FIFO.
// Ports:
//   clk, rst      clock, synchronous active-high reset
//   core_req_i    core-side request        core_resp_o  core-side response
//   acc_req_i     accelerator request      acc_resp_o   accelerator response
//   mem_req_o     memory-side request      mem_resp_i   memory-side response
module axi_mem_arbiter
    import axi_mem_arb_pkg::*;
(
    input  logic      clk,
    input  logic      rst,
    input  slv_req_t  core_req_i,
    output slv_resp_t core_resp_o,
    input  slv_req_t  acc_req_i,
    output slv_resp_t acc_resp_o,
    output mst_req_t  mem_req_o,
    input  mst_resp_t mem_resp_i
);

    localparam logic [W_FIFO_PTR_WIDTH:0] W_FIFO_FULL_CNT = (W_FIFO_PTR_WIDTH+1)'(W_FIFO_DEPTH);

    src_e ar_gnt;
    src_e aw_gnt;
    src_e w_head;
    src_e r_src;
    src_e b_src;
    logic ar_valid;
    logic aw_valid;
    logic aw_en;
    logic w_valid;
    logic w_push;
    logic w_pop;
    logic w_fifo_full;
    logic w_fifo_empty;

    logic [W_FIFO_DEPTH-1:0]     w_fifo_q;
    logic [W_FIFO_PTR_WIDTH-1:0] w_wr_ptr_q;
    logic [W_FIFO_PTR_WIDTH-1:0] w_rd_ptr_q;
    logic [W_FIFO_PTR_WIDTH:0]   w_cnt_q;

    axi_mem_arb_rr_lock u_ar_arb (
        .clk       (clk),
        .rst       (rst),
        .req       ({acc_req_i.ar_valid, core_req_i.ar_valid}),
        .gnt_en    (1'b1),
        .valid_out (ar_valid),
        .ready_in  (mem_resp_i.ar_ready),
        .gnt_src   (ar_gnt)
    );

    axi_mem_arb_rr_lock u_aw_arb (
        .clk       (clk),
        .rst       (rst),
        .req       ({acc_req_i.aw_valid, core_req_i.aw_valid}),
        .gnt_en    (aw_en),
        .valid_out (aw_valid),
        .ready_in  (mem_resp_i.aw_ready),
        .gnt_src   (aw_gnt)
    );

    // All outward valids/readies are held low while reset is asserted so no
    // handshake can complete against state that is being cleared.
    assign aw_en        = !w_fifo_full;
    assign ar_valid     = !rst && ((ar_gnt == SRC_ACC) ? acc_req_i.ar_valid : core_req_i.ar_valid);
    assign aw_valid     = !rst && aw_en &&
                          ((aw_gnt == SRC_ACC) ? acc_req_i.aw_valid : core_req_i.aw_valid);

    assign w_fifo_full  = (w_cnt_q == W_FIFO_FULL_CNT);
    assign w_fifo_empty = (w_cnt_q == '0);
    assign w_head       = src_e'(w_fifo_q[w_rd_ptr_q]);
    assign w_valid      = !rst && !w_fifo_empty &&
                          ((w_head == SRC_ACC) ? acc_req_i.w_valid : core_req_i.w_valid);

    assign w_push       = aw_valid && mem_resp_i.aw_ready;
    assign w_pop        = w_valid && mem_resp_i.w_ready && mem_req_o.w.last;

    assign r_src        = src_e'(mem_resp_i.r.id[AXI_ID_WIDTH]);
    assign b_src        = src_e'(mem_resp_i.b.id[AXI_ID_WIDTH]);

    always_ff @(posedge clk) begin
        if (rst) begin
            w_wr_ptr_q <= '0;
            w_rd_ptr_q <= '0;
            w_cnt_q    <= '0;
        end else begin
            if (w_push) begin
                w_fifo_q[w_wr_ptr_q] <= aw_gnt;
                w_wr_ptr_q           <= w_wr_ptr_q + 1'b1;
            end
            if (w_pop) begin
                w_rd_ptr_q <= w_rd_ptr_q + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   w_cnt_q <= w_cnt_q + 1'b1;
                2'b01:   w_cnt_q <= w_cnt_q - 1'b1;
                default: w_cnt_q <= w_cnt_q;
            endcase
        end
    end

    always_comb begin
        mem_req_o   = '0;
        core_resp_o = '0;
        acc_resp_o  = '0;

        mem_req_o.ar       = (ar_gnt == SRC_ACC) ? tag_ar(SRC_ACC, acc_req_i.ar)
                                                 : tag_ar(SRC_CORE, core_req_i.ar);
        mem_req_o.ar_valid = ar_valid;
        core_resp_o.ar_ready = ar_valid && mem_resp_i.ar_ready && (ar_gnt == SRC_CORE);
        acc_resp_o.ar_ready  = ar_valid && mem_resp_i.ar_ready && (ar_gnt == SRC_ACC);

        mem_req_o.aw       = (aw_gnt == SRC_ACC) ? tag_aw(SRC_ACC, acc_req_i.aw)
                                                 : tag_aw(SRC_CORE, core_req_i.aw);
        mem_req_o.aw_valid = aw_valid;
        core_resp_o.aw_ready = aw_valid && mem_resp_i.aw_ready && (aw_gnt == SRC_CORE);
        acc_resp_o.aw_ready  = aw_valid && mem_resp_i.aw_ready && (aw_gnt == SRC_ACC);

        mem_req_o.w       = (w_head == SRC_ACC) ? acc_req_i.w : core_req_i.w;
        mem_req_o.w_valid = w_valid;
        core_resp_o.w_ready = !rst && !w_fifo_empty && (w_head == SRC_CORE) && mem_resp_i.w_ready;
        acc_resp_o.w_ready  = !rst && !w_fifo_empty && (w_head == SRC_ACC) && mem_resp_i.w_ready;

        // R/B payload fans out to both masters; only the addressed one sees valid.
        core_resp_o.r.id   = mem_resp_i.r.id[AXI_ID_WIDTH-1:0];
        core_resp_o.r.data = mem_resp_i.r.data;
        core_resp_o.r.resp = mem_resp_i.r.resp;
        core_resp_o.r.last = mem_resp_i.r.last;
        core_resp_o.r.user = mem_resp_i.r.user;
        acc_resp_o.r       = core_resp_o.r;
        core_resp_o.r_valid = !rst && mem_resp_i.r_valid && (r_src == SRC_CORE);
        acc_resp_o.r_valid  = !rst && mem_resp_i.r_valid && (r_src == SRC_ACC);
        mem_req_o.r_ready   = !rst && ((r_src == SRC_ACC) ? acc_req_i.r_ready : core_req_i.r_ready);

        core_resp_o.b.id   = mem_resp_i.b.id[AXI_ID_WIDTH-1:0];
        core_resp_o.b.resp = mem_resp_i.b.resp;
        core_resp_o.b.user = mem_resp_i.b.user;
        acc_resp_o.b       = core_resp_o.b;
        core_resp_o.b_valid = !rst && mem_resp_i.b_valid && (b_src == SRC_CORE);
        acc_resp_o.b_valid  = !rst && mem_resp_i.b_valid && (b_src == SRC_ACC);
        mem_req_o.b_ready   = !rst && ((b_src == SRC_ACC) ? acc_req_i.b_ready : core_req_i.b_ready);
    end

endmodule

// File: tb/tb_axi_mem_arbiter.sv
// tb_axi_mem_arbiter
// Directed stimulus with a scoreboard: expected transfers are queued when
// stimulus is issued and a negedge monitor pops/compares on every handshake.
module tb_axi_mem_arbiter;
    import axi_mem_arb_pkg::*;

    typedef logic [191:0] key_t;

    logic      clk = 1'b0;
    logic      rst;
    slv_req_t  core_req;
    slv_resp_t core_resp;
    slv_req_t  acc_req;
    slv_resp_t acc_resp;
    mst_req_t  mem_req;
    mst_resp_t mem_resp;

    int n_cmp = 0;
    int n_err = 0;

    key_t q_ar[$];
    key_t q_aw[$];
    key_t q_w[$];
    key_t q_core_r[$];
    key_t q_acc_r[$];
    key_t q_core_b[$];
    key_t q_acc_b[$];

    axi_mem_arbiter dut (
        .clk         (clk),
        .rst         (rst),
        .core_req_i  (core_req),
        .core_resp_o (core_resp),
        .acc_req_i   (acc_req),
        .acc_resp_o  (acc_resp),
        .mem_req_o   (mem_req),
        .mem_resp_i  (mem_resp)
    );

    always #5 clk = ~clk;

    function automatic key_t k_a(input logic [4:0] id, input logic [63:0] addr);
        return key_t'({id, addr});
    endfunction
    function automatic key_t k_w(input logic last, input logic [127:0] data);
        return key_t'({last, data});
    endfunction
    function automatic key_t k_r(input logic [3:0] id, input logic [127:0] data, input logic last);
        return key_t'({id, data, last});
    endfunction
    function automatic key_t k_b(input logic [3:0] id, input logic [1:0] resp);
        return key_t'({id, resp});
    endfunction

    task automatic chk(input string name, input key_t act, input key_t exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic chk1(input string name, input logic act, input logic exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0b expected %0b", name, act, exp);
        end
    endtask

    task automatic sb(input string name, input key_t act, input logic had, input key_t exp);
        n_cmp++;
        if (!had) begin
            n_err++;
            $display("FAIL %s: unexpected transfer got %0h expected none", name, act);
        end else if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin : mon
        key_t e;
        logic had;
        if (mem_req.ar_valid && mem_resp.ar_ready) begin
            had = (q_ar.size() > 0); e = '0; if (had) e = q_ar.pop_front();
            sb("mem_ar", k_a(mem_req.ar.id, mem_req.ar.addr), had, e);
        end
        if (mem_req.aw_valid && mem_resp.aw_ready) begin
            had = (q_aw.size() > 0); e = '0; if (had) e = q_aw.pop_front();
            sb("mem_aw", k_a(mem_req.aw.id, mem_req.aw.addr), had, e);
        end
        if (mem_req.w_valid && mem_resp.w_ready) begin
            had = (q_w.size() > 0); e = '0; if (had) e = q_w.pop_front();
            sb("mem_w", k_w(mem_req.w.last, mem_req.w.data), had, e);
        end
        if (core_resp.r_valid && core_req.r_ready) begin
            had = (q_core_r.size() > 0); e = '0; if (had) e = q_core_r.pop_front();
            sb("core_r", k_r(core_resp.r.id, core_resp.r.data, core_resp.r.last), had, e);
        end
        if (acc_resp.r_valid && acc_req.r_ready) begin
            had = (q_acc_r.size() > 0); e = '0; if (had) e = q_acc_r.pop_front();
            sb("acc_r", k_r(acc_resp.r.id, acc_resp.r.data, acc_resp.r.last), had, e);
        end
        if (core_resp.b_valid && core_req.b_ready) begin
            had = (q_core_b.size() > 0); e = '0; if (had) e = q_core_b.pop_front();
            sb("core_b", k_b(core_resp.b.id, core_resp.b.resp), had, e);
        end
        if (acc_resp.b_valid && acc_req.b_ready) begin
            had = (q_acc_b.size() > 0); e = '0; if (had) e = q_acc_b.pop_front();
            sb("acc_b", k_b(acc_resp.b.id, acc_resp.b.resp), had, e);
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    initial begin : watchdog
        #50000;
        $display("FAIL watchdog: simulation time limit reached, got timeout expected $finish");
        $fatal(1, "timeout");
    end

    initial begin : stim
        int ci;
        int ai;
        logic chs;
        logic ahs;

        core_req = '0;
        acc_req  = '0;
        mem_resp = '0;
        rst      = 1'b1;
        core_req.w_valid = 1'b1;
        repeat (2) cyc();
        @(negedge clk);
        chk1("rst_mem_ar_valid", mem_req.ar_valid, 1'b0);
        chk1("rst_mem_aw_valid", mem_req.aw_valid, 1'b0);
        chk1("rst_mem_w_valid", mem_req.w_valid, 1'b0);
        chk1("rst_core_w_ready", core_resp.w_ready, 1'b0);
        chk1("rst_core_r_valid", core_resp.r_valid, 1'b0);
        chk1("rst_acc_b_valid", acc_resp.b_valid, 1'b0);
        cyc();
        rst = 1'b0;
        core_req.w_valid = 1'b0;

        // Single core read, id 3
        core_req.ar.id    = 4'h3;
        core_req.ar.addr  = 64'h1000;
        core_req.ar_valid = 1'b1;
        mem_resp.ar_ready = 1'b1;
        q_ar.push_back(k_a(5'h03, 64'h1000));
        @(negedge clk);
        chk1("ar1_core_ready", core_resp.ar_ready, 1'b1);
        chk1("ar1_acc_ready", acc_resp.ar_ready, 1'b0);
        cyc();
        core_req.ar_valid = 1'b0;

        mem_resp.r_valid  = 1'b1;
        mem_resp.r.id     = 5'h03;
        mem_resp.r.data   = 128'hC0DE;
        mem_resp.r.last   = 1'b1;
        core_req.r_ready  = 1'b1;
        q_core_r.push_back(k_r(4'h3, 128'hC0DE, 1'b1));
        @(negedge clk);
        chk1("r1_acc_valid", acc_resp.r_valid, 1'b0);
        chk1("r1_mem_ready", mem_req.r_ready, 1'b1);
        cyc();

        // R to acc while acc stalls: mem r_ready follows acc, not core
        mem_resp.r.id   = 5'h15;
        mem_resp.r.data = 128'hACC1;
        acc_req.r_ready = 1'b0;
        @(negedge clk);
        chk1("r2_mem_ready_stall", mem_req.r_ready, 1'b0);
        chk1("r2_core_valid", core_resp.r_valid, 1'b0);
        chk1("r2_acc_valid", acc_resp.r_valid, 1'b1);
        cyc();
        acc_req.r_ready = 1'b1;
        q_acc_r.push_back(k_r(4'h5, 128'hACC1, 1'b1));
        cyc();
        mem_resp.r_valid = 1'b0;
        acc_req.r_ready  = 1'b0;
        core_req.r_ready = 1'b0;

        // Acc alone: pointer returns to core
        acc_req.ar.id    = 4'h2;
        acc_req.ar.addr  = 64'hA0;
        acc_req.ar_valid = 1'b1;
        q_ar.push_back(k_a(5'h12, 64'hA0));
        cyc();

        // Both valid for 4 handshakes: core, acc, core, acc
        core_req.ar.id    = 4'h1;
        core_req.ar.addr  = 64'hC0;
        core_req.ar_valid = 1'b1;
        q_ar.push_back(k_a(5'h01, 64'hC0));
        q_ar.push_back(k_a(5'h12, 64'hA0));
        q_ar.push_back(k_a(5'h01, 64'hC0));
        q_ar.push_back(k_a(5'h12, 64'hA0));
        repeat (4) cyc();
        core_req.ar_valid = 1'b0;
        acc_req.ar_valid  = 1'b0;

        // Lock: acc presented first with ar_ready low, core joins
        mem_resp.ar_ready = 1'b0;
        acc_req.ar.id     = 4'h7;
        acc_req.ar.addr   = 64'hA5;
        acc_req.ar_valid  = 1'b1;
        cyc();
        core_req.ar.id    = 4'h6;
        core_req.ar.addr  = 64'hC5;
        core_req.ar_valid = 1'b1;
        repeat (5) begin
            @(negedge clk);
            chk("lock_ar_addr", key_t'(mem_req.ar.addr), key_t'(64'hA5));
            chk1("lock_core_ar_ready", core_resp.ar_ready, 1'b0);
            cyc();
        end
        mem_resp.ar_ready = 1'b1;
        q_ar.push_back(k_a(5'h17, 64'hA5));
        cyc();
        acc_req.ar_valid = 1'b0;
        q_ar.push_back(k_a(5'h06, 64'hC5));
        cyc();
        core_req.ar_valid = 1'b0;

        // Interleaved writes: core len 3 then acc len 1, acc W shown first
        mem_resp.aw_ready = 1'b1;
        mem_resp.w_ready  = 1'b1;
        core_req.aw.id    = 4'h1;
        core_req.aw.addr  = 64'h3000;
        core_req.aw.len   = 8'd3;
        acc_req.aw.id     = 4'h2;
        acc_req.aw.addr   = 64'h4000;
        acc_req.aw.len    = 8'd1;
        q_aw.push_back(k_a(5'h01, 64'h3000));
        q_aw.push_back(k_a(5'h12, 64'h4000));
        for (int i = 0; i < 4; i++) q_w.push_back(k_w(i == 3, {96'h0, 32'hC00 + i}));
        for (int i = 0; i < 2; i++) q_w.push_back(k_w(i == 1, {96'h0, 32'hA00 + i}));
        ci = 0;
        ai = 0;
        for (int c = 0; c < 12 && !(ci == 4 && ai == 2); c++) begin
            core_req.aw_valid = (c == 0);
            acc_req.aw_valid  = (c == 1);
            core_req.w_valid  = (ci < 4);
            core_req.w.data   = {96'h0, 32'hC00 + ci};
            core_req.w.last   = (ci == 3);
            acc_req.w_valid   = (ai < 2);
            acc_req.w.data    = {96'h0, 32'hA00 + ai};
            acc_req.w.last    = (ai == 1);
            @(negedge clk);
            if (c == 0) chk1("w_wait_aw_cycle", mem_req.w_valid, 1'b0);
            if (ci < 4) chk1("acc_w_ready_blocked", acc_resp.w_ready, 1'b0);
            chs = core_req.w_valid && core_resp.w_ready;
            ahs = acc_req.w_valid && acc_resp.w_ready;
            cyc();
            if (chs) ci++;
            if (ahs) ai++;
        end
        chk1("w_all_beats_done", (ci == 4 && ai == 2), 1'b1);
        core_req.aw_valid = 1'b0;
        acc_req.aw_valid  = 1'b0;
        core_req.w_valid  = 1'b0;
        acc_req.w_valid   = 1'b0;

        // B routing
        mem_resp.b_valid = 1'b1;
        mem_resp.b.id    = 5'h12;
        mem_resp.b.resp  = 2'b00;
        acc_req.b_ready  = 1'b1;
        q_acc_b.push_back(k_b(4'h2, 2'b00));
        @(negedge clk);
        chk1("b1_core_valid", core_resp.b_valid, 1'b0);
        cyc();
        mem_resp.b.id    = 5'h01;
        mem_resp.b.resp  = 2'b10;
        core_req.b_ready = 1'b1;
        q_core_b.push_back(k_b(4'h1, 2'b10));
        @(negedge clk);
        chk1("b2_acc_valid", acc_resp.b_valid, 1'b0);
        cyc();
        mem_resp.b_valid = 1'b0;
        core_req.b_ready = 1'b0;
        acc_req.b_ready  = 1'b0;

        // W FIFO full: 4 AWs with W withheld, fifth blocked
        core_req.aw.len = 8'd0;
        for (int i = 0; i < 4; i++) begin
            core_req.aw.id    = 4'(i);
            core_req.aw.addr  = 64'h5000 + 64'(i * 16);
            core_req.aw_valid = 1'b1;
            q_aw.push_back(k_a({1'b0, 4'(i)}, 64'h5000 + 64'(i * 16)));
            cyc();
        end
        core_req.aw.id   = 4'h4;
        core_req.aw.addr = 64'h5040;
        acc_req.aw.id    = 4'h9;
        acc_req.aw.addr  = 64'h9000;
        acc_req.aw_valid = 1'b1;
        repeat (2) begin
            @(negedge clk);
            chk1("full_mem_aw_valid", mem_req.aw_valid, 1'b0);
            chk1("full_core_aw_ready", core_resp.aw_ready, 1'b0);
            chk1("full_acc_aw_ready", acc_resp.aw_ready, 1'b0);
            cyc();
        end
        acc_req.aw_valid = 1'b0;
        core_req.w_valid = 1'b1;
        core_req.w.data  = 128'hF0;
        core_req.w.last  = 1'b1;
        q_w.push_back(k_w(1'b1, 128'hF0));
        @(negedge clk);
        chk1("full_pop_cycle_aw_valid", mem_req.aw_valid, 1'b0);
        cyc();
        core_req.w_valid = 1'b0;
        q_aw.push_back(k_a(5'h04, 64'h5040));
        @(negedge clk);
        chk1("after_pop_core_aw_ready", core_resp.aw_ready, 1'b1);
        cyc();
        core_req.aw_valid = 1'b0;

        // Reset mid-burst: 2 of 4 beats sent
        q_w.push_back(k_w(1'b0, 128'hD0));
        q_w.push_back(k_w(1'b0, 128'hD1));
        for (int b = 0; b < 2; b++) begin
            core_req.w_valid = 1'b1;
            core_req.w.data  = {96'h0, 32'hD0 + b};
            core_req.w.last  = 1'b0;
            cyc();
        end
        rst = 1'b1;
        core_req.w.data   = 128'hD2;
        core_req.ar.id    = 4'hE;
        core_req.ar.addr  = 64'hE000;
        core_req.ar_valid = 1'b1;
        @(negedge clk);
        chk1("in_rst_mem_w_valid", mem_req.w_valid, 1'b0);
        chk1("in_rst_mem_ar_valid", mem_req.ar_valid, 1'b0);
        cyc();
        rst = 1'b0;
        core_req.ar_valid = 1'b0;
        @(negedge clk);
        chk1("post_rst_fifo_empty_w_valid", mem_req.w_valid, 1'b0);
        chk1("post_rst_core_w_ready", core_resp.w_ready, 1'b0);
        chk1("post_rst_mem_aw_valid", mem_req.aw_valid, 1'b0);
        cyc();
        core_req.w_valid  = 1'b0;
        core_req.ar.id    = 4'hA;
        core_req.ar.addr  = 64'h6000;
        core_req.ar_valid = 1'b1;
        acc_req.ar.id     = 4'hB;
        acc_req.ar.addr   = 64'h7000;
        acc_req.ar_valid  = 1'b1;
        q_ar.push_back(k_a(5'h0A, 64'h6000));
        q_ar.push_back(k_a(5'h1B, 64'h7000));
        cyc();
        core_req.ar_valid = 1'b0;
        cyc();
        acc_req.ar_valid  = 1'b0;
        mem_resp.r_valid  = 1'b1;
        mem_resp.r.id     = 5'h0A;
        mem_resp.r.data   = 128'h600D;
        mem_resp.r.last   = 1'b1;
        core_req.r_ready  = 1'b1;
        q_core_r.push_back(k_r(4'hA, 128'h600D, 1'b1));
        cyc();
        mem_resp.r_valid = 1'b0;
        core_req.r_ready = 1'b0;
        repeat (2) cyc();

        chk("q_ar_drained", key_t'(q_ar.size()), '0);
        chk("q_aw_drained", key_t'(q_aw.size()), '0);
        chk("q_w_drained", key_t'(q_w.size()), '0);
        chk("q_r_drained", key_t'(q_core_r.size() + q_acc_r.size()), '0);
        chk("q_b_drained", key_t'(q_core_b.size() + q_acc_b.size()), '0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
